// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style bus between the fetch and data ports. An access takes IDLE -> BUSY -> DONE (3 cycles minimum).
// Bus signals are held stable until ack or timeout; each port stalls until its own DONE cycle.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DATA_PRIORITY  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_stallreq_o,
    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_stallreq_o,
    input  logic        flush_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [2:0] {IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flushed_q, flushed_d;

    logic take_d, take_i, is_d, discard;

    assign take_d  = d_ce_i & (DATA_PRIORITY | ~if_ce_i);
    assign take_i  = if_ce_i & ~take_d;
    assign is_d    = (state_q == D_BUSY);
    // A flush arriving in the ack cycle itself also discards the result.
    assign discard = flushed_q | flush_i;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        flushed_d  = flushed_q;
        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                cnt_d     = 8'd0;
                if (!flush_i && take_d) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    sel_d   = d_sel_i;
                    wdata_d = d_wdata_i;
                    state_d = D_BUSY;
                end else if (!flush_i && take_i) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    sel_d   = 4'b1111;
                    wdata_d = 32'd0;
                    state_d = I_BUSY;
                end
            end
            D_BUSY, I_BUSY: begin
                flushed_d = discard;
                if (bus_ack_i || cnt_q == CNT_LAST) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    cnt_d     = 8'd0;
                    flushed_d = 1'b0;
                    err_d     = ~bus_ack_i;
                    if (discard) begin
                        state_d = IDLE;
                    end else if (is_d) begin
                        if (!bus_ack_i)     d_rdata_d = 32'd0;
                        else if (!we_q)     d_rdata_d = bus_rdata_i;
                        state_d = D_DONE;
                    end else begin
                        if_rdata_d = bus_ack_i ? bus_rdata_i : 32'd0;
                        state_d    = I_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            sel_q      <= 4'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
        end
    end

    assign bus_cyc_o     = cyc_q;
    assign bus_stb_o     = stb_q;
    assign bus_we_o      = we_q;
    assign bus_addr_o    = addr_q;
    assign bus_sel_o     = sel_q;
    assign bus_wdata_o   = wdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign d_rdata_o     = d_rdata_q;
    assign bus_err_o     = err_q;
    assign d_stallreq_o  = d_ce_i & (state_q != D_DONE);
    assign if_stallreq_o = if_ce_i & (state_q != I_DONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized requester/slave run checked against a transaction-level model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_stallreq_o;
    logic        d_ce_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [3:0]  d_sel_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_stallreq_o;
    logic        flush_i = 1'b0;
    logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .DATA_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_stallreq_o(if_stallreq_o),
        .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_stallreq_o(d_stallreq_o),
        .flush_i(flush_i),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, if_rdata_o, d_rdata_o, bus_err_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cyc=%b stb=%b addr=%h ird=%h drd=%h err=%b required all zero",
                     bus_cyc_o, bus_stb_o, bus_addr_o, if_rdata_o, d_rdata_o, bus_err_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, if_stallreq_o} !== {3'b110, 32'h100, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL fetch_issue got cyc=%b stb=%b we=%b addr=%h sel=%h stall=%b required 1 1 0 00000100 f 1",
                     bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, if_stallreq_o);
        end
        @(negedge clk);
        checks++;
        if ({bus_stb_o, if_stallreq_o} !== 2'b11) begin
            failures++;
            $display("FAIL fetch_hold got stb=%b stall=%b required 1 1", bus_stb_o, if_stallreq_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3C01_0001;
        @(negedge clk);
        checks++;
        if ({bus_stb_o, if_stallreq_o, if_rdata_o} !== {2'b00, 32'h3C01_0001}) begin
            failures++;
            $display("FAIL fetch_done got stb=%b stall=%b rdata=%h required 0 0 3c010001", bus_stb_o, if_stallreq_o, if_rdata_o);
        end
        bus_ack_i = 1'b0; if_ce_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_sel_i = 4'hF;
        if_ce_i = 1'b1; if_addr_i = 32'h104;
        @(negedge clk);
        checks++;
        if ({bus_stb_o, bus_we_o, bus_addr_o, if_stallreq_o, d_stallreq_o} !== {2'b10, 32'h200, 2'b11}) begin
            failures++;
            $display("FAIL simul_data_first got stb=%b we=%b addr=%h istall=%b dstall=%b required 1 0 00000200 1 1",
                     bus_stb_o, bus_we_o, bus_addr_o, if_stallreq_o, d_stallreq_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h11;
        @(negedge clk);
        checks++;
        if ({d_stallreq_o, d_rdata_o, if_stallreq_o} !== {1'b0, 32'h11, 1'b1}) begin
            failures++;
            $display("FAIL simul_data_done got dstall=%b drd=%h istall=%b required 0 00000011 1", d_stallreq_o, d_rdata_o, if_stallreq_o);
        end
        bus_ack_i = 1'b0; d_ce_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_stb_o, if_stallreq_o} !== 2'b01) begin
            failures++;
            $display("FAIL simul_idle_gap got stb=%b istall=%b required 0 1", bus_stb_o, if_stallreq_o);
        end
        @(negedge clk);
        checks++;
        if ({bus_stb_o, bus_addr_o, bus_sel_o} !== {1'b1, 32'h104, 4'hF}) begin
            failures++;
            $display("FAIL simul_fetch_issue got stb=%b addr=%h sel=%h required 1 00000104 f", bus_stb_o, bus_addr_o, bus_sel_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h22;
        @(negedge clk);
        checks++;
        if ({if_stallreq_o, if_rdata_o} !== {1'b0, 32'h22}) begin
            failures++;
            $display("FAIL simul_fetch_done got istall=%b ird=%h required 0 00000022", if_stallreq_o, if_rdata_o);
        end
        bus_ack_i = 1'b0; if_ce_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        d_ce_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h80; d_sel_i = 4'b0100; d_wdata_i = 32'h00AB_0000;
        @(negedge clk);
        checks++;
        if ({bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {2'b11, 32'h80, 4'b0100, 32'h00AB_0000}) begin
            failures++;
            $display("FAIL store_issue got stb=%b we=%b addr=%h sel=%b wdata=%h required 1 1 00000080 0100 00ab0000",
                     bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({d_stallreq_o, d_rdata_o, bus_stb_o} !== {1'b0, 32'h11, 1'b0}) begin
            failures++;
            $display("FAIL store_done got dstall=%b drd=%h stb=%b required 0 00000011 0", d_stallreq_o, d_rdata_o, bus_stb_o);
        end
        bus_ack_i = 1'b0; d_ce_i = 1'b0; d_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; d_sel_i = 4'hF;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_stb_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_no_abort got stb=%b required 1", bus_stb_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD;
        @(negedge clk);
        checks++;
        if ({bus_stb_o, d_stallreq_o, d_rdata_o} !== {2'b01, 32'h11}) begin
            failures++;
            $display("FAIL flush_discard got stb=%b dstall=%b drd=%h required 0 1 00000011", bus_stb_o, d_stallreq_o, d_rdata_o);
        end
        bus_ack_i = 1'b0;
        @(negedge clk);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h55;
        @(negedge clk);
        checks++;
        if ({d_stallreq_o, d_rdata_o} !== {1'b0, 32'h55}) begin
            failures++;
            $display("FAIL flush_flag_cleared got dstall=%b drd=%h required 0 00000055", d_stallreq_o, d_rdata_o);
        end
        bus_ack_i = 1'b0; d_ce_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_cyc_o, bus_stb_o, bus_err_o, d_stallreq_o} !== 4'b1101) begin
                failures++;
                $display("FAIL timeout_wait%0d got cyc=%b stb=%b err=%b dstall=%b required 1 1 0 1",
                         k, bus_cyc_o, bus_stb_o, bus_err_o, d_stallreq_o);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_err_o, d_stallreq_o, d_rdata_o} !== {4'b0010, 32'h0}) begin
            failures++;
            $display("FAIL timeout_done got cyc=%b stb=%b err=%b dstall=%b drd=%h required 0 0 1 0 00000000",
                     bus_cyc_o, bus_stb_o, bus_err_o, d_stallreq_o, d_rdata_o);
        end
        d_ce_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_err_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse got err=%b required 0", bus_err_o);
        end
    endtask

    task automatic test_random();
        bit dq = 0, iq = 0, last_dq = 0, busy = 0, done_pend = 0, own_d = 0;
        logic we_r = 0;
        logic [31:0] da = 0, dw = 0, ia = 0, exp_d = 32'h0, exp_i = 32'h22;
        logic [3:0] ds = 0;
        int wt = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            checks++;
            if (bus_err_o !== 1'b0) begin
                failures++;
                $display("FAIL rand_err n=%0d got err=%b required 0", n, bus_err_o);
            end
            if (done_pend) begin
                checks++;
                if (own_d ? ({d_stallreq_o, d_rdata_o, if_stallreq_o, bus_stb_o} !== {1'b0, exp_d, iq, 1'b0})
                          : ({if_stallreq_o, if_rdata_o, d_stallreq_o, bus_stb_o} !== {1'b0, exp_i, dq, 1'b0})) begin
                    failures++;
                    $display("FAIL rand_done n=%0d owner_d=%b got dstall=%b drd=%h istall=%b ird=%h stb=%b required drd=%h ird=%h",
                             n, own_d, d_stallreq_o, d_rdata_o, if_stallreq_o, if_rdata_o, bus_stb_o, exp_d, exp_i);
                end
                if (own_d) dq = 0; else iq = 0;
                done_pend = 0;
            end else if (busy || bus_stb_o) begin
                if (!busy) begin
                    own_d = last_dq; busy = 1; wt = 0;
                    checks++;
                    if ({bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o} !== {1'b1, own_d ? we_r : 1'b0, own_d ? da : ia, own_d ? ds : 4'hF}) begin
                        failures++;
                        $display("FAIL rand_issue n=%0d owner_d=%b got we=%b addr=%h sel=%h", n, own_d, bus_we_o, bus_addr_o, bus_sel_o);
                    end
                    if (own_d && we_r) begin
                        checks++;
                        if (bus_wdata_o !== dw) begin
                            failures++;
                            $display("FAIL rand_wdata n=%0d got %h required %h", n, bus_wdata_o, dw);
                        end
                    end
                end
                checks++;
                if ({bus_stb_o, d_stallreq_o, if_stallreq_o} !== {1'b1, dq, iq}) begin
                    failures++;
                    $display("FAIL rand_busy n=%0d got stb=%b dstall=%b istall=%b required 1 %b %b", n, bus_stb_o, d_stallreq_o, if_stallreq_o, dq, iq);
                end
                if (wt == 2 || $urandom_range(0, 2) == 0) begin
                    bus_ack_i = 1'b1; bus_rdata_i = $urandom;
                    if (own_d) begin
                        if (!we_r) exp_d = bus_rdata_i;
                    end else begin
                        exp_i = bus_rdata_i;
                    end
                    busy = 0; done_pend = 1;
                end
                wt++;
            end
            if (n < 560) begin
                if (!dq && $urandom_range(0, 2) == 0) begin
                    dq = 1; we_r = 1'($urandom_range(0, 1)); da = $urandom; ds = 4'($urandom); dw = $urandom;
                end
                if (!iq && $urandom_range(0, 2) == 0) begin
                    iq = 1; ia = $urandom;
                end
            end
            d_ce_i = dq; d_we_i = we_r; d_addr_i = da; d_sel_i = ds; d_wdata_i = dw;
            if_ce_i = iq; if_addr_i = ia;
            last_dq = dq;
        end
        checks++;
        if (busy || done_pend || dq || iq) begin
            failures++;
            $display("FAIL rand_drain got busy=%b done=%b dq=%b iq=%b required all 0", busy, done_pend, dq, iq);
        end
        bus_ack_i = 1'b0; d_ce_i = 1'b0; if_ce_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        if_ce_i = 1'b1; if_addr_i = 32'h500;
        @(negedge clk);
        checks++;
        if ({bus_cyc_o, bus_stb_o} !== 2'b11) begin
            failures++;
            $display("FAIL areset_busy got cyc=%b stb=%b required 1 1", bus_cyc_o, bus_stb_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_addr_o, bus_sel_o, if_rdata_o, d_rdata_o, bus_err_o} !== '0) begin
            failures++;
            $display("FAIL areset_immediate got cyc=%b stb=%b addr=%h ird=%h drd=%h required all zero",
                     bus_cyc_o, bus_stb_o, bus_addr_o, if_rdata_o, d_rdata_o);
        end
        if_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_stb_o, if_stallreq_o} !== 2'b00) begin
            failures++;
            $display("FAIL areset_idle got stb=%b istall=%b required 0 0", bus_stb_o, if_stallreq_o);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_flush();
        test_timeout();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external Wishbone-style bus between the instruction-fetch port and the MEM-stage data port.
- Sequences each access as cyc/stb → ack and holds the bus signals stable while it waits.
- Raises per-port stall requests to the pipeline controller.
- Sits between the IF stage / MEM stage outputs (ce, we, addr, sel, data) and the SoC bus. It handles flush (exception) and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in a BUSY state without ack before the access is aborted (8-bit counter, range 1..255).
- DATA_PRIORITY, 1: 1 means the data port wins simultaneous requests; 0 means fetch wins.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_ce_i  in  1  fetch request
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction
- if_stallreq_o  out  1  fetch stall request
- d_ce_i  in  1  data request
- d_we_i  in  1  data write enable
- d_addr_i  in  32  data address
- d_sel_i  in  4  byte selects
- d_wdata_i  in  32  store data
- d_rdata_o  out  32  load data
- d_stallreq_o  out  1  data stall request
- flush_i  in  1  pipeline flush (exception/eret)
- bus_cyc_o  out  1  bus cycle
- bus_stb_o  out  1  bus strobe
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  bus address
- bus_sel_o  out  4  bus byte selects
- bus_wdata_o  out  32  bus write data
- bus_rdata_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, rst=1): state IDLE; all bus_* outputs 0; if_rdata_o and d_rdata_o 0; bus_err_o 0; timeout counter 0; flushed flag 0.
- Registered outputs: all bus_* outputs, both rdata outputs and bus_err_o.
- Combinational outputs: the stall requests, decoded from state and the ce inputs.

States:
- IDLE:
  - flush_i=1: stay in IDLE, issue nothing.
  - Otherwise the winning request (priority per DATA_PRIORITY) is latched into the bus_* registers with cyc=stb=1, and the state moves to D_BUSY or I_BUSY.
  - bus_we_o=0 and bus_sel_o=4'b1111 for fetch.
- D_BUSY / I_BUSY:
  - bus_* outputs are held constant; the counter increments each cycle.
  - On bus_ack_i=1: capture bus_rdata_i into the port's rdata register (reads only; writes leave d_rdata_o unchanged), drop cyc/stb, clear the counter, go to D_DONE / I_DONE.
  - If the flushed flag is set at ack, discard the data and go to IDLE instead.
  - Counter reaching TIMEOUT_CYCLES without ack: drop cyc/stb, load rdata=0, pulse bus_err_o, go to DONE (or to IDLE if flushed).
- D_DONE / I_DONE: one cycle; the owning port's stall is released and rdata is valid; next state is IDLE.
- Stall rules:
  - d_stallreq_o = d_ce_i & ~(state==D_DONE).
  - if_stallreq_o = if_ce_i & ~(state==I_DONE).
  - Every request stalls until its own DONE cycle, including while the other port owns the bus.
- Flush during BUSY: the bus cycle is never aborted. The flushed flag is set, the transfer completes on ack, and the result is discarded. The flag is cleared on entering IDLE.
- flush_i during DONE: no effect; state still returns to IDLE.
- Latency:
  - Request visible at edge t → stb high after t.
  - Ack sampled at edge t+k → DONE after t+k.
  - Minimum 3 cycles per access (IDLE, BUSY, DONE).
- Back-to-back requests: IDLE is re-entered between every access, so no request is issued from a DONE cycle.
- Under DATA_PRIORITY=1 with continuous data requests, fetch waits.

Test Plan:
- Fetch only: if_ce_i=1, addr 0x00000100, ack on 2nd BUSY cycle with rdata 0x3C010001 → stb high 2 cycles, if_rdata_o=0x3C010001 in I_DONE, if_stallreq_o low exactly that cycle.
- Store: d_ce_i=d_we_i=1, addr 0x80, sel 4'b0100, wdata 0x00AB0000, immediate ack → bus_we_o=1, bus_sel_o=4'b0100, d_rdata_o unchanged, d_stallreq_o low in D_DONE.
- Simultaneous request, DATA_PRIORITY=1: load at 0x200 (returns 0x11) and fetch at 0x104 (returns 0x22) → data served first, then fetch. if_stallreq_o stays high through D_DONE and drops only in I_DONE; rdata 0x11 and 0x22 respectively.
- Flush mid-load: flush_i pulsed during D_BUSY, ack 3 cycles later with 0xDEAD → d_rdata_o keeps its old value, state goes to IDLE, no DONE cycle, flushed flag cleared.
- Timeout: TIMEOUT_CYCLES=4, load with no ack → cyc/stb drop after 4 BUSY cycles, bus_err_o high 1 cycle, d_rdata_o=0, d_stallreq_o released in D_DONE.
- Async reset asserted mid-I_BUSY → bus_cyc_o/bus_stb_o drop immediately without a clock edge, state IDLE, all outputs 0.
